// File: rtl/beam_topk_sort.sv
// Top-K beam selector: ranks COL beam powers with an all-pairs compare pipeline
// and queues the leading TOPK {index, power} pairs plus RBG number in a result FIFO.
module beam_topk_sort #(
  parameter int IW        = 32,
  parameter int COL       = 64,
  parameter int TOPK      = 16,
  parameter int RBG_DEPTH = 16,
  localparam int IDXW     = $clog2(COL)
) (
  input  logic                           i_clk,
  input  logic                           i_reset,
  input  logic [COL-1:0][IW-1:0]         i_data,
  input  logic                           i_valid,
  output logic                           o_ready,
  input  logic                           i_descend,
  input  logic                           i_sop,
  input  logic [7:0]                     i_rbg_max,
  input  logic                           i_rd_en,
  output logic                           o_rd_valid,
  output logic [TOPK-1:0][IDXW-1:0]      o_beam_index,
  output logic [TOPK-1:0][IW-1:0]        o_beam_power,
  output logic [7:0]                     o_rbg_num,
  output logic                           o_empty,
  output logic                           o_full
);

  localparam int PW = $clog2(RBG_DEPTH);
  localparam int RW = IDXW + 1;

  typedef logic [TOPK-1:0][IDXW-1:0] idx_vec_t;
  typedef logic [TOPK-1:0][IW-1:0]   pow_vec_t;

  logic                   w_accept, w_pop, w_wr, w_ready;
  logic [7:0]             w_rbg_next;
  logic [RW-1:0]          w_rank [COL];
  idx_vec_t               w_slot_idx;
  pow_vec_t               w_slot_pow;

  logic [PW:0]            r_credit, r_count;
  logic [PW-1:0]          r_wr_ptr, r_rd_ptr;
  logic [7:0]             r_rbg;
  logic                   r_rbg_first;

  logic                   r_s0_valid, r_s0_desc;
  logic [COL-1:0][IW-1:0] r_s0_data;
  logic [7:0]             r_s0_rbg;

  logic                   r_s1_valid;
  logic [RW-1:0]          r_s1_rank [COL];
  logic [COL-1:0][IW-1:0] r_s1_data;
  logic [7:0]             r_s1_rbg;

  logic                   r_s2_valid;
  idx_vec_t               r_s2_idx;
  pow_vec_t               r_s2_pow;
  logic [7:0]             r_s2_rbg;

  idx_vec_t               r_mem_idx [RBG_DEPTH];
  pow_vec_t               r_mem_pow [RBG_DEPTH];
  logic [7:0]             r_mem_rbg [RBG_DEPTH];

  // Equal powers are broken in favour of the lower beam index, so ranks are a permutation.
  function automatic logic beats(input logic [IW-1:0] dj, input logic [IW-1:0] di,
                                 input logic jlow, input logic desc);
    logic b;
    if (dj == di)  b = jlow;
    else if (desc) b = (dj > di);
    else           b = (dj < di);
    return b;
  endfunction

  assign w_ready  = (r_credit != '0);
  assign o_ready  = w_ready;
  assign o_full   = ~w_ready;
  assign o_empty  = (r_count == '0);
  assign w_accept = i_valid && w_ready;
  assign w_pop    = i_rd_en && (r_count != '0);
  assign w_wr     = r_s2_valid;

  // The first vector after reset starts numbering at 0 even without i_sop.
  assign w_rbg_next = (i_sop || r_rbg_first || (r_rbg == i_rbg_max)) ? 8'd0 : r_rbg + 8'd1;

  always_comb begin
    for (int i = 0; i < COL; i++) begin
      w_rank[i] = '0;
      for (int j = 0; j < COL; j++) begin
        if (j != i && beats(r_s0_data[j], r_s0_data[i], (j < i), r_s0_desc))
          w_rank[i] = w_rank[i] + RW'(1);
      end
    end
  end

  always_comb begin
    w_slot_idx = '0;
    w_slot_pow = '0;
    for (int r = 0; r < TOPK; r++) begin
      for (int i = 0; i < COL; i++) begin
        if (r_s1_rank[i] == RW'(r)) begin
          w_slot_idx[r] = IDXW'(i);
          w_slot_pow[r] = r_s1_data[i];
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_rbg       <= '0;
      r_rbg_first <= 1'b1;
      r_s0_valid  <= 1'b0;
      r_s0_desc   <= 1'b0;
      r_s0_data   <= '0;
      r_s0_rbg    <= '0;
      r_s1_valid  <= 1'b0;
      r_s1_data   <= '0;
      r_s1_rbg    <= '0;
      for (int i = 0; i < COL; i++) r_s1_rank[i] <= '0;
      r_s2_valid  <= 1'b0;
      r_s2_idx    <= '0;
      r_s2_pow    <= '0;
      r_s2_rbg    <= '0;
    end else begin
      r_s0_valid <= w_accept;
      if (w_accept) begin
        r_s0_data   <= i_data;
        r_s0_desc   <= i_descend;
        r_s0_rbg    <= w_rbg_next;
        r_rbg       <= w_rbg_next;
        r_rbg_first <= 1'b0;
      end
      r_s1_valid <= r_s0_valid;
      r_s1_data  <= r_s0_data;
      r_s1_rbg   <= r_s0_rbg;
      for (int i = 0; i < COL; i++) r_s1_rank[i] <= w_rank[i];
      r_s2_valid <= r_s1_valid;
      r_s2_idx   <= w_slot_idx;
      r_s2_pow   <= w_slot_pow;
      r_s2_rbg   <= r_s1_rbg;
    end
  end

  // Credits cover in-flight vectors as well as stored entries, so writes never overflow.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_credit     <= (PW+1)'(RBG_DEPTH);
      r_count      <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      o_rd_valid   <= 1'b0;
      o_beam_index <= '0;
      o_beam_power <= '0;
      o_rbg_num    <= '0;
    end else begin
      case ({w_accept, w_pop})
        2'b10:   r_credit <= r_credit - (PW+1)'(1);
        2'b01:   r_credit <= r_credit + (PW+1)'(1);
        default: r_credit <= r_credit;
      endcase
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
      if (w_wr) r_wr_ptr <= r_wr_ptr + PW'(1);
      o_rd_valid <= w_pop;
      if (w_pop) begin
        r_rd_ptr     <= r_rd_ptr + PW'(1);
        o_beam_index <= r_mem_idx[r_rd_ptr];
        o_beam_power <= r_mem_pow[r_rd_ptr];
        o_rbg_num    <= r_mem_rbg[r_rd_ptr];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_wr) begin
      r_mem_idx[r_wr_ptr] <= r_s2_idx;
      r_mem_pow[r_wr_ptr] <= r_s2_pow;
      r_mem_rbg[r_wr_ptr] <= r_s2_rbg;
    end
  end

endmodule

// File: tb/tb_beam_topk_sort.sv
// Bench for beam_topk_sort: a stable-sort reference model with a per-cycle compare
// process, plus directed vectors with hand-computed literal expectations.
module tb_beam_topk_sort;

  localparam int IW        = 32;
  localparam int COL       = 64;
  localparam int TOPK      = 16;
  localparam int RBG_DEPTH = 16;
  localparam int IDXW      = $clog2(COL);

  typedef logic [TOPK-1:0][IDXW-1:0] idxv_t;
  typedef logic [TOPK-1:0][IW-1:0]   powv_t;
  typedef logic [COL-1:0][IW-1:0]    datv_t;

  logic        i_clk = 1'b0;
  logic        i_reset;
  datv_t       i_data;
  logic        i_valid, i_descend, i_sop, i_rd_en;
  logic [7:0]  i_rbg_max;
  logic        o_ready, o_rd_valid, o_empty, o_full;
  idxv_t       o_beam_index;
  powv_t       o_beam_power;
  logic [7:0]  o_rbg_num;

  beam_topk_sort #(.IW(IW), .COL(COL), .TOPK(TOPK), .RBG_DEPTH(RBG_DEPTH)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_data(i_data), .i_valid(i_valid),
    .o_ready(o_ready), .i_descend(i_descend), .i_sop(i_sop), .i_rbg_max(i_rbg_max),
    .i_rd_en(i_rd_en), .o_rd_valid(o_rd_valid), .o_beam_index(o_beam_index),
    .o_beam_power(o_beam_power), .o_rbg_num(o_rbg_num), .o_empty(o_empty), .o_full(o_full)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int failures = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic checkOutputVec(input string name, input logic [TOPK*IW-1:0] act,
                                input logic [TOPK*IW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference ranking: stable insertion sort, so equal powers keep ascending index order.
  function automatic void buildEntry(input datv_t d, input bit desc,
                                     output idxv_t idx, output powv_t pow);
    int ord[$];
    int p;
    for (int k = 0; k < COL; k++) begin
      p = ord.size();
      for (int q = 0; q < ord.size(); q++) begin
        if (desc ? (d[k] > d[ord[q]]) : (d[k] < d[ord[q]])) begin
          p = q;
          break;
        end
      end
      ord.insert(p, k);
    end
    for (int r = 0; r < TOPK; r++) begin
      idx[r] = IDXW'(ord[r]);
      pow[r] = d[ord[r]];
    end
  endfunction

  // Model state: every accepted vector waits in these queues until popped.
  idxv_t      qIdx[$];
  powv_t      qPow[$];
  logic [7:0] qRbg[$];
  int         qAvail[$];
  int         edgeN = 0;
  bit         mFirst = 1'b1;
  logic [7:0] mRbg = '0;
  bit         mRdValid = 1'b0;
  idxv_t      mIdx = '0;
  powv_t      mPow = '0;
  logic [7:0] mRbgOut = '0;
  bit         mAcc, mPop;
  idxv_t      eIdx;
  powv_t      ePow;

  initial forever begin
    @(posedge i_clk);
    if (i_reset) begin
      qIdx.delete(); qPow.delete(); qRbg.delete(); qAvail.delete();
      mFirst = 1'b1; mRbg = '0; mRdValid = 1'b0;
      mIdx = '0; mPow = '0; mRbgOut = '0;
    end else begin
      edgeN++;
      mAcc = i_valid && (qRbg.size() < RBG_DEPTH);
      mPop = i_rd_en && (qRbg.size() > 0) && (qAvail[0] < edgeN);
      mRdValid = mPop;
      if (mPop) begin
        mIdx = qIdx.pop_front();
        mPow = qPow.pop_front();
        mRbgOut = qRbg.pop_front();
        void'(qAvail.pop_front());
      end
      if (mAcc) begin
        mRbg = (i_sop || mFirst || mRbg == i_rbg_max) ? 8'd0 : mRbg + 8'd1;
        mFirst = 1'b0;
        buildEntry(i_data, i_descend, eIdx, ePow);
        qIdx.push_back(eIdx);
        qPow.push_back(ePow);
        qRbg.push_back(mRbg);
        qAvail.push_back(edgeN + 3);
      end
    end
  end

  // Compare process: outputs against the model on every cycle out of reset.
  initial forever begin
    @(negedge i_clk);
    if (!i_reset) begin
      checkOutput("ready", 64'(o_ready), 64'(qRbg.size() < RBG_DEPTH));
      checkOutput("full", 64'(o_full), 64'(qRbg.size() >= RBG_DEPTH));
      checkOutput("empty", 64'(o_empty), 64'(!(qRbg.size() > 0 && qAvail[0] <= edgeN)));
      checkOutput("rd_valid", 64'(o_rd_valid), 64'(mRdValid));
      checkOutputVec("beam_index", (TOPK*IW)'(o_beam_index), (TOPK*IW)'(mIdx));
      checkOutputVec("beam_power", (TOPK*IW)'(o_beam_power), (TOPK*IW)'(mPow));
      checkOutput("rbg_num", 64'(o_rbg_num), 64'(mRbgOut));
    end
  end

  task automatic applyStimulus(input bit v, input bit sop, input bit desc,
                               input datv_t d, input bit rd);
    i_valid = v; i_sop = sop; i_descend = desc; i_data = d; i_rd_en = rd;
    @(negedge i_clk);
  endtask

  task automatic waitCycles(input int n);
    for (int c = 0; c < n; c++) applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_rd_valid"}, 64'(o_rd_valid), 64'd0);
    checkOutput({tag, "_empty"}, 64'(o_empty), 64'd1);
    checkOutput({tag, "_full"}, 64'(o_full), 64'd0);
    checkOutput({tag, "_ready"}, 64'(o_ready), 64'd1);
    checkOutput({tag, "_rbg"}, 64'(o_rbg_num), 64'd0);
    checkOutputVec({tag, "_index"}, (TOPK*IW)'(o_beam_index), '0);
    checkOutputVec({tag, "_power"}, (TOPK*IW)'(o_beam_power), '0);
  endtask

  datv_t d;
  int accepted;
  int seqA[10] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1};
  int seqB[10] = '{0, 1, 2, 3, 0, 0, 1, 2, 3, 0};

  initial begin
    i_reset = 1'b1; i_valid = 1'b0; i_sop = 1'b0; i_descend = 1'b0;
    i_data = '0; i_rd_en = 1'b0; i_rbg_max = 8'd255;
    repeat (2) @(negedge i_clk);
    checkResetValues("reset");
    i_reset = 1'b0;

    // Distinct descending powers
    for (int k = 0; k < COL; k++) d[k] = IW'(k * 10);
    applyStimulus(1'b1, 1'b1, 1'b1, d, 1'b0);
    checkOutput("t1_empty_e0", 64'(o_empty), 64'd1);
    waitCycles(1); checkOutput("t1_empty_e1", 64'(o_empty), 64'd1);
    waitCycles(1); checkOutput("t1_empty_e2", 64'(o_empty), 64'd1);
    waitCycles(1); checkOutput("t1_empty_e3", 64'(o_empty), 64'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);
    checkOutput("t1_rd_valid", 64'(o_rd_valid), 64'd1);
    checkOutput("t1_idx0", 64'(o_beam_index[0]), 64'd63);
    checkOutput("t1_idx15", 64'(o_beam_index[15]), 64'd48);
    checkOutput("t1_pow0", 64'(o_beam_power[0]), 64'd630);
    checkOutput("t1_pow15", 64'(o_beam_power[15]), 64'd480);
    checkOutput("t1_rbg", 64'(o_rbg_num), 64'd0);
    waitCycles(1);
    checkOutput("t1_rd_valid_drop", 64'(o_rd_valid), 64'd0);
    checkOutput("t1_idx0_hold", 64'(o_beam_index[0]), 64'd63);

    // Ties in ascending mode
    for (int k = 0; k < COL; k++) d[k] = IW'(5);
    d[7] = IW'(1);
    applyStimulus(1'b1, 1'b0, 1'b0, d, 1'b0);
    waitCycles(3);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);
    checkOutput("t2_idx0", 64'(o_beam_index[0]), 64'd7);
    checkOutput("t2_idx1", 64'(o_beam_index[1]), 64'd0);
    checkOutput("t2_idx7", 64'(o_beam_index[7]), 64'd6);
    checkOutput("t2_idx8", 64'(o_beam_index[8]), 64'd8);
    checkOutput("t2_pow0", 64'(o_beam_power[0]), 64'd1);
    checkOutput("t2_pow1", 64'(o_beam_power[1]), 64'd5);
    checkOutput("t2_rbg", 64'(o_rbg_num), 64'd1);

    // Pop while empty is ignored
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);
    checkOutput("t3_no_rd_valid", 64'(o_rd_valid), 64'd0);
    checkOutput("t3_idx0_hold", 64'(o_beam_index[0]), 64'd7);
    for (int k = 0; k < COL; k++) d[k] = IW'(1000 - k);
    applyStimulus(1'b1, 1'b0, 1'b1, d, 1'b0);
    waitCycles(3);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);
    checkOutput("t3_rd_valid", 64'(o_rd_valid), 64'd1);
    checkOutput("t3_idx0", 64'(o_beam_index[0]), 64'd0);
    checkOutput("t3_pow0", 64'(o_beam_power[0]), 64'd1000);
    checkOutput("t3_rbg", 64'(o_rbg_num), 64'd2);

    // Backpressure: no pops while streaming 20 vectors
    waitCycles(1);
    accepted = 0;
    for (int v = 0; v < 20; v++) begin
      for (int k = 0; k < COL; k++) d[k] = IW'((k * 7 + v * 13) % 50);
      if (o_ready) accepted++;
      applyStimulus(1'b1, v == 0, v[0], d, 1'b0);
    end
    checkOutput("t4_accepted", 64'(accepted), 64'd16);
    checkOutput("t4_full", 64'(o_full), 64'd1);
    applyStimulus(1'b1, 1'b0, 1'b1, d, 1'b1);
    checkOutput("t4_ready_after_pop", 64'(o_ready), 64'd1);
    applyStimulus(1'b1, 1'b0, 1'b1, d, 1'b0);
    checkOutput("t4_full_again", 64'(o_full), 64'd1);
    applyStimulus(1'b0, 1'b0, 1'b1, d, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1, d, 1'b1);
    checkOutput("t4_credit_hold", 64'(o_ready), 64'd1);
    for (int c = 0; c < 24; c++) applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);
    waitCycles(2);
    checkOutput("t4_drained_empty", 64'(o_empty), 64'd1);
    checkOutput("t4_drained_ready", 64'(o_ready), 64'd1);

    // RBG numbering with wrap and mid-stream i_sop
    i_rbg_max = 8'd3;
    for (int v = 0; v < 10; v++) begin
      for (int k = 0; k < COL; k++) d[k] = IW'(k + v);
      applyStimulus(1'b1, v == 0, 1'b1, d, 1'b0);
    end
    waitCycles(3);
    for (int v = 0; v < 10; v++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);
      checkOutput($sformatf("t5_rbg_a%0d", v), 64'(o_rbg_num), 64'(seqA[v]));
    end
    for (int v = 0; v < 10; v++) begin
      for (int k = 0; k < COL; k++) d[k] = IW'(3 * k + v);
      applyStimulus(1'b1, (v == 0) || (v == 5), 1'b0, d, 1'b0);
    end
    waitCycles(3);
    for (int v = 0; v < 10; v++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);
      checkOutput($sformatf("t5_rbg_b%0d", v), 64'(o_rbg_num), 64'(seqB[v]));
    end

    // Reset with entries stored and vectors in flight
    for (int v = 0; v < 6; v++) begin
      for (int k = 0; k < COL; k++) d[k] = IW'(100 + k * v);
      applyStimulus(1'b1, 1'b0, 1'b1, d, 1'b0);
    end
    waitCycles(3);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);
    checkOutput("t6_pre_rbg", 64'(o_rbg_num), 64'd1);
    applyStimulus(1'b1, 1'b0, 1'b1, d, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, d, 1'b0);
    i_valid = 1'b0;
    i_reset = 1'b1;
    @(negedge i_clk);
    checkResetValues("t6_reset");
    i_reset = 1'b0;
    waitCycles(4);
    checkOutput("t6_no_leak", 64'(o_empty), 64'd1);
    for (int k = 0; k < COL; k++) d[k] = IW'(k * 10);
    applyStimulus(1'b1, 1'b0, 1'b1, d, 1'b0);
    waitCycles(3);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);
    checkOutput("t6_post_rbg", 64'(o_rbg_num), 64'd0);
    checkOutput("t6_post_idx0", 64'(o_beam_index[0]), 64'd63);

    waitCycles(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
